adc_multi_reader: RTL and testbench

Parametrised serial ADC readout engine and successor to the single-width ADC/FPGA link. It drives one shared SClk/CsN pair to TotalAdcs parallel serial ADCs and deserialises AdcBits-wide samples, discarding LeadBits leading bits per frame. It runs a burst of iNumConv conversions per start and writes each ADC's sample into that ADC's FIFO. It sits between the readout sequencer (start/busy/compl handshake) and the per-ADC FIFOs.

---
 rtl/adc_multi_reader_if.sv | 35 +++
 rtl/adc_multi_reader.sv | 185 ++++++++++++++++++
 tb/tb_adc_multi_reader.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_multi_reader_if.sv
// adc_multi_reader_if
//   Bundles every signal of the ADC readout engine except clk and rst:
//   - sequencer handshake: iEn, iStart, iNumConv, oBusy, oCompl, oError
//   - ADC serial link:     oSClk, oCsN, iSData (one lane per ADC)
//   - per-ADC FIFO side:   oFifoData, oFifoWr, iFifoFull
//   The slave modport is the engine's view; master is the view of the
//   surrounding sequencer, ADCs and FIFOs.
interface adc_multi_reader_if #(
   parameter int TotalAdcs = 10,
   parameter int AdcBits   = 12,
   parameter int ConvW     = 8
);
   logic                           iEn;
   logic                           iStart;
   logic [ConvW-1:0]               iNumConv;
   logic                           oBusy;
   logic                           oCompl;
   logic                           oError;
   logic                           oSClk;
   logic                           oCsN;
   logic [TotalAdcs-1:0]           iSData;
   logic [TotalAdcs*AdcBits-1:0]   oFifoData;
   logic [TotalAdcs-1:0]           oFifoWr;
   logic [TotalAdcs-1:0]           iFifoFull;

   modport slave (
      input  iEn, iStart, iNumConv, iSData, iFifoFull,
      output oBusy, oCompl, oError, oSClk, oCsN, oFifoData, oFifoWr
   );

   modport master (
      output iEn, iStart, iNumConv, iSData, iFifoFull,
      input  oBusy, oCompl, oError, oSClk, oCsN, oFifoData, oFifoWr
   );
endinterface

// File: rtl/adc_multi_reader.sv
// adc_multi_reader
//   Serial readout engine for TotalAdcs parallel ADCs sharing one SClk/CsN
//   pair. Each start runs a burst of iNumConv conversions; every conversion
//   clocks FrameBits = LeadBits + AdcBits bits per lane (MSB first), keeps
//   the last AdcBits and writes them to that lane's FIFO.
//   Ports:
//     clk  - system clock
//     rst  - asynchronous reset, active-low
//     bus  - adc_multi_reader_if.slave (handshake, ADC link, FIFO side)
module adc_multi_reader #(
   parameter int TotalAdcs  = 10,
   parameter int AdcBits    = 12,
   parameter int LeadBits   = 4,
   parameter int SclkDiv    = 2,
   parameter int QuietTicks = 2,
   parameter int ConvW      = 8
) (
   input logic                clk,
   input logic                rst,
   adc_multi_reader_if.slave  bus
);

   localparam int FrameBits = LeadBits + AdcBits;
   localparam int DivW      = (SclkDiv > 1) ? $clog2(SclkDiv) : 1;
   localparam int CntMax    = (FrameBits > QuietTicks) ? FrameBits : QuietTicks;
   localparam int CntW      = $clog2(CntMax + 1);

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_CS_SETUP   = 3'd1;
   localparam logic [2:0] ST_SHIFT      = 3'd2;
   localparam logic [2:0] ST_CS_RELEASE = 3'd3;
   localparam logic [2:0] ST_DONE       = 3'd4;

   logic [2:0]                          state_q, state_d;
   logic [DivW-1:0]                     div_q, div_d;
   logic [CntW-1:0]                     cnt_q, cnt_d;   // SHIFT: bits taken, CS_RELEASE: ticks
   logic                                sclk_q, sclk_d;
   logic [ConvW-1:0]                    conv_q, conv_d;
   logic [ConvW-1:0]                    num_q, num_d;
   logic                                err_q, err_d;
   logic [TotalAdcs-1:0]                wr_q, wr_d;
   logic [TotalAdcs-1:0][AdcBits-1:0]   shift_q, shift_d;
   logic [TotalAdcs-1:0][AdcBits-1:0]   data_q, data_d;
   logic                                tick;

   assign tick = (div_q == DivW'(SclkDiv - 1));

   always_comb begin
      // NOTE: every signal gets its hold value first so no path leaves it
      // unassigned; otherwise synthesis would infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      sclk_d  = sclk_q;
      conv_d  = conv_q;
      num_d   = num_q;
      err_d   = err_q;
      wr_d    = '0;
      shift_d = shift_q;
      data_d  = data_q;
      div_d   = '0;

      case (state_q)
         ST_IDLE: begin
            sclk_d = 1'b1;
            if (bus.iEn && bus.iStart) begin
               num_d   = bus.iNumConv;
               err_d   = 1'b0;
               conv_d  = '0;
               state_d = (bus.iNumConv == '0) ? ST_DONE : ST_CS_SETUP;
            end
         end
         ST_CS_SETUP: begin
            if (tick) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
            end
         end
         ST_SHIFT: begin
            if (tick) begin
               sclk_d = ~sclk_q;
               // Rising SClk: take one bit per lane. Leading bits fall out of
               // the top of the AdcBits-wide shifter on their own.
               if (!sclk_q) begin
                  for (int k = 0; k < TotalAdcs; k++)
                     shift_d[k] = {shift_q[k][AdcBits-2:0], bus.iSData[k]};
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CntW'(FrameBits - 1)) begin
                     state_d = ST_CS_RELEASE;
                     cnt_d   = '0;
                     conv_d  = conv_q + 1'b1;
                     for (int k = 0; k < TotalAdcs; k++) begin
                        if (!bus.iFifoFull[k]) begin
                           wr_d[k]   = 1'b1;
                           data_d[k] = shift_d[k];
                        end else begin
                           err_d = 1'b1;
                        end
                     end
                  end
               end
            end
         end
         ST_CS_RELEASE: begin
            sclk_d = 1'b1;
            if (tick) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntW'(QuietTicks - 1)) begin
                  cnt_d   = '0;
                  state_d = (conv_q < num_q) ? ST_CS_SETUP : ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            sclk_d  = 1'b1;
         end
      endcase

      // Enable low abandons the burst: no write, no completion, and the
      // sticky error keeps whatever it had before this cycle.
      if (state_q != ST_IDLE && !bus.iEn) begin
         state_d = ST_IDLE;
         sclk_d  = 1'b1;
         cnt_d   = '0;
         conv_d  = conv_q;
         err_d   = err_q;
         wr_d    = '0;
         shift_d = shift_q;
         data_d  = data_q;
      end

      // Half-period divider restarts on every state change and is frozen
      // while the engine is idle or completing.
      if (state_d != state_q || state_q == ST_IDLE || state_q == ST_DONE)
         div_d = '0;
      else if (tick)
         div_d = '0;
      else
         div_d = div_q + 1'b1;
   end

   // NOTE: the FIFO data registers are ordinary flops, not a memory, so they
   // can and do take the asynchronous reset like the rest of the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         sclk_q  <= 1'b1;
         conv_q  <= '0;
         num_q   <= '0;
         err_q   <= 1'b0;
         wr_q    <= '0;
         shift_q <= '0;
         data_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         sclk_q  <= sclk_d;
         conv_q  <= conv_d;
         num_q   <= num_d;
         err_q   <= err_d;
         wr_q    <= wr_d;
         shift_q <= shift_d;
         data_q  <= data_d;
      end
   end

   // CsN and the handshake flags decode straight from the state register so
   // they follow the asynchronous reset without waiting for a clock.
   assign bus.oSClk     = sclk_q;
   assign bus.oCsN      = !(state_q == ST_CS_SETUP || state_q == ST_SHIFT);
   assign bus.oBusy     = (state_q != ST_IDLE);
   assign bus.oCompl    = (state_q == ST_DONE);
   assign bus.oError    = err_q;
   assign bus.oFifoWr   = wr_q;
   assign bus.oFifoData = data_q;

endmodule

// File: tb/tb_adc_multi_reader.sv
// tb_adc_multi_reader
//   Directed bench for adc_multi_reader with default parameters. A driver
//   process plays the ADCs (one bit per falling SClk from a per-lane frame
//   table) and the FIFO full flags; scenario tasks drive the sequencer side
//   and compare against hand-computed values.
module tb_adc_multi_reader;
   localparam int TA = 10;
   localparam int AB = 12;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst;
   logic clk_run = 1'b1;
   int   checks = 0;
   int   errors = 0;

   adc_multi_reader_if #(.TotalAdcs(TA), .AdcBits(AB), .ConvW(CW)) bus ();

   adc_multi_reader #(
      .TotalAdcs(TA), .AdcBits(AB), .LeadBits(4),
      .SclkDiv(2), .QuietTicks(2), .ConvW(CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   // ADC / FIFO model. Frame for lane k in conversion i (counted from
   // conv_base) is base[k] + i*step, sent MSB first.
   logic [15:0]   base [TA];
   logic [15:0]   step;
   int            conv_base;
   int            full_conv;
   logic [TA-1:0] full_mask;
   int            conv_cnt = 0;
   int            bit_idx  = 0;
   logic          d_pc = 1'b1;
   logic          d_ps = 1'b1;

   always @(negedge clk) begin : adc_model
      logic [15:0] f;
      if (d_pc && !bus.oCsN) begin
         conv_cnt++;
         bit_idx = 0;
      end
      if (!bus.oCsN && d_ps && !bus.oSClk && bit_idx < 16) begin
         for (int k = 0; k < TA; k++) begin
            f = base[k] + 16'((conv_cnt - conv_base) * step);
            bus.iSData[k] = f[15 - bit_idx];
         end
         bit_idx++;
      end
      bus.iFifoFull = (conv_cnt - conv_base == full_conv) ? full_mask : '0;
      d_pc = bus.oCsN;
      d_ps = bus.oSClk;
   end

   // Observations collected by watch()
   int            wr_cnt [TA];
   logic [AB-1:0] wr_data [TA][4];
   int            wr_cyc [4];
   logic [TA-1:0] first_wr_mask;
   int            compl_cnt, compl_cyc, fall_cyc, rise_cnt, n_gaps;
   int            gap_len [4];
   logic          busy_after;
   logic          timed_out;

   task automatic start_burst(input int n);
      @(negedge clk);
      bus.iNumConv = CW'(n);
      bus.iStart   = 1'b1;
      @(negedge clk);
      bus.iStart   = 1'b0;
   endtask

   // Observe from the current negedge until 3 cycles past oCompl.
   task automatic watch(input int max_cyc);
      logic pc, ps;
      int   hi_run;
      wr_cnt = '{default: 0};
      first_wr_mask = '0;
      compl_cnt = 0; compl_cyc = -1; fall_cyc = -1; rise_cnt = 0; n_gaps = 0;
      busy_after = 1'bx; timed_out = 1'b1;
      pc = 1'b1; ps = 1'b1; hi_run = 0;
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (pc && !bus.oCsN) begin
            if (fall_cyc < 0) fall_cyc = cyc;
            else if (n_gaps < 4) begin gap_len[n_gaps] = hi_run; n_gaps++; end
         end
         hi_run = bus.oCsN ? hi_run + 1 : 0;
         if (!ps && bus.oSClk) rise_cnt++;
         if (bus.oFifoWr != '0 && first_wr_mask == '0) first_wr_mask = bus.oFifoWr;
         for (int k = 0; k < TA; k++) begin
            if (bus.oFifoWr[k]) begin
               if (wr_cnt[k] < 4) wr_data[k][wr_cnt[k]] = bus.oFifoData[k*AB +: AB];
               if (k == 0 && wr_cnt[0] < 4) wr_cyc[wr_cnt[0]] = cyc;
               wr_cnt[k]++;
            end
         end
         if (bus.oCompl) begin
            compl_cnt++;
            if (compl_cyc < 0) compl_cyc = cyc;
         end
         if (compl_cyc >= 0 && cyc == compl_cyc + 1) busy_after = bus.oBusy;
         if (compl_cyc >= 0 && cyc == compl_cyc + 3) begin
            timed_out = 1'b0;
            break;
         end
         pc = bus.oCsN;
         ps = bus.oSClk;
      end
   endtask

   task automatic test_reset;
      #12;
      checks++;
      if ({bus.oCsN, bus.oSClk, bus.oBusy, bus.oCompl, bus.oError} !== 5'b11000) begin
         errors++;
         $display("FAIL reset_flags: got %b want 11000",
                  {bus.oCsN, bus.oSClk, bus.oBusy, bus.oCompl, bus.oError});
      end
      checks++;
      if (bus.oFifoWr !== '0 || bus.oFifoData !== '0) begin
         errors++;
         $display("FAIL reset_fifo: got wr=%h data=%h want 0", bus.oFifoWr, bus.oFifoData);
      end
      @(negedge clk);
      rst    = 1'b1;
      bus.iEn = 1'b1;
   endtask

   task automatic test_single;
      conv_base = conv_cnt;
      base = '{default: 16'h0000};
      base[0] = 16'h0A5C;
      step = 16'h0000;
      start_burst(1);
      watch(300);
      checks++;
      if (timed_out !== 1'b0) begin errors++; $display("FAIL single_timeout: got no oCompl want oCompl"); end
      checks++;
      if (first_wr_mask !== {TA{1'b1}}) begin
         errors++; $display("FAIL single_wr_mask: got %b want all ones", first_wr_mask);
      end
      checks++;
      if (wr_cnt[0] !== 1 || wr_data[0][0] !== 12'hA5C) begin
         errors++; $display("FAIL single_lane0: got n=%0d d=%h want n=1 d=a5c", wr_cnt[0], wr_data[0][0]);
      end
      checks++;
      if (wr_data[5][0] !== 12'h000) begin
         errors++; $display("FAIL single_lane5: got %h want 000", wr_data[5][0]);
      end
      checks++;
      if (compl_cyc - fall_cyc !== 70) begin
         errors++; $display("FAIL single_latency: got %0d want 70", compl_cyc - fall_cyc);
      end
      checks++;
      if (rise_cnt !== 16) begin errors++; $display("FAIL single_rises: got %0d want 16", rise_cnt); end
      checks++;
      if (compl_cnt !== 1 || busy_after !== 1'b0) begin
         errors++; $display("FAIL single_compl: got n=%0d busy=%b want n=1 busy=0", compl_cnt, busy_after);
      end
      checks++;
      if (bus.oFifoData[AB-1:0] !== 12'hA5C) begin
         errors++; $display("FAIL single_hold: got %h want a5c", bus.oFifoData[AB-1:0]);
      end
   endtask

   task automatic test_burst;
      conv_base = conv_cnt;
      base = '{default: 16'h0000};
      step = 16'h0001;
      start_burst(3);
      watch(600);
      checks++;
      if (timed_out !== 1'b0 || compl_cnt !== 1) begin
         errors++; $display("FAIL burst_compl: got to=%b n=%0d want to=0 n=1", timed_out, compl_cnt);
      end
      checks++;
      if (wr_cnt[0] !== 3 || wr_cnt[9] !== 3) begin
         errors++; $display("FAIL burst_writes: got %0d/%0d want 3/3", wr_cnt[0], wr_cnt[9]);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (wr_data[0][i] !== AB'(i + 1) || wr_data[9][i] !== AB'(i + 1)) begin
            errors++; $display("FAIL burst_data%0d: got %h/%h want %h", i, wr_data[0][i], wr_data[9][i], i + 1);
         end
      end
      checks++;
      if (wr_cyc[1] - wr_cyc[0] !== 70 || wr_cyc[2] - wr_cyc[1] !== 70) begin
         errors++; $display("FAIL burst_spacing: got %0d,%0d want 70,70",
                            wr_cyc[1] - wr_cyc[0], wr_cyc[2] - wr_cyc[1]);
      end
      checks++;
      if (n_gaps !== 2 || gap_len[0] !== 4 || gap_len[1] !== 4) begin
         errors++; $display("FAIL burst_csn_gap: got n=%0d %0d,%0d want n=2 4,4", n_gaps, gap_len[0], gap_len[1]);
      end
   endtask

   task automatic test_full;
      conv_base = conv_cnt;
      for (int k = 0; k < TA; k++) base[k] = 16'(k);
      step = 16'h0100;
      full_mask = TA'(1) << 3;
      full_conv = 2;
      start_burst(3);
      watch(600);
      full_mask = '0;
      checks++;
      if (wr_cnt[3] !== 2 || wr_cnt[0] !== 3 || wr_cnt[9] !== 3) begin
         errors++; $display("FAIL full_writes: got %0d/%0d/%0d want 2/3/3", wr_cnt[3], wr_cnt[0], wr_cnt[9]);
      end
      checks++;
      if (wr_data[3][0] !== 12'h103 || wr_data[3][1] !== 12'h303 || wr_data[2][1] !== 12'h202) begin
         errors++; $display("FAIL full_data: got %h %h %h want 103 303 202",
                            wr_data[3][0], wr_data[3][1], wr_data[2][1]);
      end
      checks++;
      if (bus.oError !== 1'b1) begin errors++; $display("FAIL full_error_set: got %b want 1", bus.oError); end
      conv_base = conv_cnt;
      start_burst(1);
      checks++;
      if (bus.oError !== 1'b0) begin errors++; $display("FAIL full_error_clear: got %b want 0", bus.oError); end
      watch(300);
      checks++;
      if (compl_cnt !== 1 || wr_cnt[3] !== 1) begin
         errors++; $display("FAIL full_rerun: got compl=%0d wr3=%0d want 1/1", compl_cnt, wr_cnt[3]);
      end
   endtask

   task automatic test_abort;
      logic ps;
      int   rises, n_wr, n_compl;
      conv_base = conv_cnt;
      base = '{default: 16'h0000};
      base[0] = 16'hF123;
      step = 16'h0000;
      start_burst(2);
      ps = bus.oSClk; rises = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (!ps && bus.oSClk) rises++;
         ps = bus.oSClk;
         if (rises == 10) begin bus.iEn = 1'b0; break; end
      end
      checks++;
      if (rises !== 10) begin errors++; $display("FAIL abort_reach: got %0d rises want 10", rises); end
      @(negedge clk);
      checks++;
      if ({bus.oCsN, bus.oSClk, bus.oBusy} !== 3'b110) begin
         errors++; $display("FAIL abort_idle: got %b want 110", {bus.oCsN, bus.oSClk, bus.oBusy});
      end
      n_wr = 0; n_compl = 0;
      for (int c = 0; c < 150; c++) begin
         if (bus.oFifoWr != '0) n_wr++;
         if (bus.oCompl) n_compl++;
         @(negedge clk);
      end
      checks++;
      if (n_wr !== 0 || n_compl !== 0) begin
         errors++; $display("FAIL abort_quiet: got wr=%0d compl=%0d want 0/0", n_wr, n_compl);
      end
      bus.iEn = 1'b1;
      conv_base = conv_cnt;
      start_burst(1);
      watch(300);
      checks++;
      if (compl_cnt !== 1 || wr_cnt[0] !== 1 || wr_data[0][0] !== 12'h123) begin
         errors++; $display("FAIL abort_restart: got compl=%0d n=%0d d=%h want 1/1/123",
                            compl_cnt, wr_cnt[0], wr_data[0][0]);
      end
   endtask

   task automatic test_zero;
      int falls;
      start_burst(0);
      checks++;
      if ({bus.oCompl, bus.oBusy, bus.oCsN} !== 3'b111) begin
         errors++; $display("FAIL zero_compl: got %b want 111", {bus.oCompl, bus.oBusy, bus.oCsN});
      end
      falls = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!bus.oCsN || bus.oCompl) falls++;
      end
      checks++;
      if (falls !== 0 || bus.oBusy !== 1'b0) begin
         errors++; $display("FAIL zero_after: got activity=%0d busy=%b want 0/0", falls, bus.oBusy);
      end
   endtask

   task automatic test_async_reset;
      int c;
      conv_base = conv_cnt;
      start_burst(1);
      for (c = 0; c < 100; c++) begin
         if (!bus.oCsN && !bus.oSClk) break;
         @(negedge clk);
      end
      checks++;
      if (c == 100 || bus.oFifoData === '0) begin
         errors++; $display("FAIL arst_setup: got cyc=%0d data=%h want mid-shift with held data", c, bus.oFifoData);
      end
      clk_run = 1'b0;
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({bus.oCsN, bus.oSClk, bus.oBusy, bus.oCompl, bus.oError} !== 5'b11000 ||
          bus.oFifoWr !== '0 || bus.oFifoData !== '0) begin
         errors++; $display("FAIL arst_values: got %b wr=%h data=%h want 11000 0 0",
                            {bus.oCsN, bus.oSClk, bus.oBusy, bus.oCompl, bus.oError},
                            bus.oFifoWr, bus.oFifoData);
      end
      #4 rst = 1'b1;
      clk_run = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (bus.oBusy !== 1'b0 || bus.oCsN !== 1'b1) begin
         errors++; $display("FAIL arst_stay_idle: got busy=%b csn=%b want 0/1", bus.oBusy, bus.oCsN);
      end
   endtask

   initial begin
      rst          = 1'b0;
      bus.iEn      = 1'b0;
      bus.iStart   = 1'b0;
      bus.iNumConv = '0;
      base         = '{default: 16'h0000};
      step         = 16'h0000;
      conv_base    = 0;
      full_conv    = 0;
      full_mask    = '0;
      test_reset;
      test_single;
      test_burst;
      test_full;
      test_abort;
      test_zero;
      test_async_reset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
